// File: rtl/parity_sched.sv
// Round-robin scheduler sharing one serial parity engine between N_REQ requesters.
// Grants one requester, launches the engine, waits on its busy handshake and returns parity.
module parity_sched #(
   parameter int N_REQ   = 4,
   parameter int DW      = 8,
   parameter int TIMEOUT = 15,
   localparam int GW     = (N_REQ > 1) ? $clog2(N_REQ) : 1,
   localparam int CW     = $clog2(TIMEOUT + 1)
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ*DW-1:0] req_data,
   output logic [N_REQ-1:0]    ack,
   output logic                res_even,
   output logic                res_odd,
   output logic                res_err,
   output logic [GW-1:0]       grant_id,
   output logic                active,
   output logic                par_start,
   output logic [DW-1:0]       par_data,
   input  logic                par_busy,
   input  logic                par_even,
   input  logic                par_odd
);

   typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_BUSY, RUN, DONE} state_t;

   state_t        state, state_d;
   logic [GW-1:0] ptr;
   logic [CW-1:0] wd_cnt;
   logic          win_vld;
   logic [GW-1:0] win_id;
   logic [GW:0]   probe;
   logic [DW-1:0] words [N_REQ];

   // Round-robin search: walk offsets downward so the lowest offset from ptr wins.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      win_vld = 1'b0;
      win_id  = '0;
      probe   = '0;
      for (int i = N_REQ - 1; i >= 0; i--) begin
         probe = {1'b0, ptr} + (GW + 1)'(i);
         if (probe >= (GW + 1)'(N_REQ))
            probe = probe - (GW + 1)'(N_REQ);
         if (req[probe[GW-1:0]]) begin
            win_vld = 1'b1;
            win_id  = probe[GW-1:0];
         end
      end
   end

   always_comb begin
      for (int i = 0; i < N_REQ; i++)
         words[i] = req_data[i*DW +: DW];
   end

   always_comb begin
      state_d = state;
      case (state)
         IDLE:      if (win_vld) state_d = LAUNCH;
         LAUNCH:    state_d = WAIT_BUSY;
         WAIT_BUSY: begin
            if (par_busy)
               state_d = RUN;
            else if (wd_cnt == CW'(TIMEOUT))
               state_d = DONE;
         end
         RUN:       if (!par_busy) state_d = DONE;
         DONE:      state_d = IDLE;
         default:   state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= state_d;
   end

   // Outputs are registered from the next state so they line up with the state they describe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ack       <= '0;
         res_even  <= 1'b0;
         res_odd   <= 1'b0;
         res_err   <= 1'b0;
         grant_id  <= '0;
         active    <= 1'b0;
         par_start <= 1'b0;
         par_data  <= '0;
         ptr       <= '0;
         wd_cnt    <= '0;
      end else begin
         par_start <= (state_d == LAUNCH);
         active    <= (state_d != IDLE);
         ack       <= (state_d == DONE) ? (N_REQ'(1) << grant_id) : '0;
         case (state)
            IDLE: begin
               if (win_vld) begin
                  grant_id <= win_id;
                  par_data <= words[win_id];
               end
            end
            LAUNCH: wd_cnt <= '0;
            WAIT_BUSY: begin
               if (!par_busy) begin
                  if (wd_cnt == CW'(TIMEOUT)) begin
                     res_even <= 1'b0;
                     res_odd  <= 1'b0;
                     res_err  <= 1'b1;
                  end else begin
                     wd_cnt <= wd_cnt + 1'b1;
                  end
               end
            end
            RUN: begin
               if (!par_busy) begin
                  res_even <= par_even;
                  res_odd  <= par_odd;
                  res_err  <= 1'b0;
               end
            end
            DONE: begin
               if (grant_id == GW'(N_REQ - 1))
                  ptr <= '0;
               else
                  ptr <= grant_id + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_parity_sched.sv
// Directed self-checking bench for parity_sched with a small busy-handshake engine stub.
// Expected values are hand-computed from the word popcounts and the cycle timeline.
module tb_parity_sched;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  req;
   logic [31:0] req_data;
   logic [3:0]  ack;
   logic        res_even, res_odd, res_err;
   logic [1:0]  grant_id;
   logic        active, par_start;
   logic [7:0]  par_data;
   logic        par_busy = 1'b0;
   logic        par_even, par_odd;

   int checks   = 0;
   int failures = 0;
   int starts   = 0;
   int eng_len  = 8;
   int eng_left = 0;
   logic eng_en = 1'b1;

   parity_sched #(.N_REQ(4), .DW(8), .TIMEOUT(15)) dut (
      .clk(clk), .reset(reset), .req(req), .req_data(req_data), .ack(ack),
      .res_even(res_even), .res_odd(res_odd), .res_err(res_err),
      .grant_id(grant_id), .active(active), .par_start(par_start),
      .par_data(par_data), .par_busy(par_busy), .par_even(par_even), .par_odd(par_odd)
   );

   always #5 clk = ~clk;

   // Engine stub: busy rises the cycle after it sees start and stays high for eng_len cycles.
   assign par_even = ^par_data;
   assign par_odd  = ~^par_data;

   always @(posedge clk) begin
      if (eng_en && par_start) begin
         par_busy <= 1'b1;
         eng_left <= eng_len - 1;
      end else if (par_busy) begin
         if (eng_left == 0) par_busy <= 1'b0;
         else               eng_left <= eng_left - 1;
      end
   end

   always @(posedge clk) if (par_start) starts <= starts + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Counts negedges from request (cycle 1 = first negedge after the grant edge) until ack.
   task automatic wait_ack(input string tag, output int n, output logic [7:0] pd1);
      logic seen;
      seen = 1'b0;
      n    = 0;
      pd1  = '0;
      for (int k = 0; k < 80 && !seen; k++) begin
         @(negedge clk);
         n++;
         if (n == 1) pd1 = par_data;
         if (ack != 4'b0000) seen = 1'b1;
      end
      check({tag, "_ack_seen"}, 32'(seen), 1);
   endtask

   initial begin
      int n, base;
      logic [7:0] pd;
      int order [5];
      order = '{0, 1, 2, 3, 0};

      reset = 1'b1;
      req = 4'b0000;
      req_data = '0;
      repeat (2) @(negedge clk);
      check("rst_ack", 32'(ack), 0);
      check("rst_active", 32'(active), 0);
      check("rst_start", 32'(par_start), 0);
      check("rst_grant", 32'(grant_id), 0);
      reset = 1'b0;
      @(negedge clk);

      // Single request from requester 2, engine busy 8 cycles
      eng_len = 8;
      base = starts;
      req_data = 32'h00A5_0000;
      req = 4'b0100;
      wait_ack("single", n, pd);
      req = 4'b0000;
      check("single_latency", 32'(n), 11);
      check("single_ack", 32'(ack), 32'h4);
      check("single_grant", 32'(grant_id), 2);
      check("single_pdata", 32'(pd), 32'hA5);
      check("single_even", 32'(res_even), 0);
      check("single_odd", 32'(res_odd), 1);
      check("single_err", 32'(res_err), 0);
      check("single_active", 32'(active), 1);
      check("single_starts", 32'(starts - base), 1);
      @(negedge clk);
      check("single_ack_pulse", 32'(ack), 0);
      check("single_active_drop", 32'(active), 0);

      // Odd popcount from requester 0 (pointer at 3 wraps to 0), busy 3 cycles
      eng_len = 3;
      req_data = 32'h0000_0007;
      req = 4'b0001;
      wait_ack("oddpop", n, pd);
      req = 4'b0000;
      check("oddpop_latency", 32'(n), 6);
      check("oddpop_ack", 32'(ack), 32'h1);
      check("oddpop_even", 32'(res_even), 1);
      check("oddpop_odd", 32'(res_odd), 0);
      @(negedge clk);

      // Watchdog: engine never raises busy
      eng_en = 1'b0;
      req_data = 32'h0000_0100;
      req = 4'b0010;
      wait_ack("wdog", n, pd);
      req = 4'b0000;
      check("wdog_latency", 32'(n), 18);
      check("wdog_ack", 32'(ack), 32'h2);
      check("wdog_err", 32'(res_err), 1);
      check("wdog_even", 32'(res_even), 0);
      check("wdog_odd", 32'(res_odd), 0);
      @(negedge clk);
      check("wdog_err_held", 32'(res_err), 1);

      // Next good transaction clears the error
      eng_en = 1'b1;
      eng_len = 2;
      req_data = 32'h0003_0000;
      req = 4'b0100;
      wait_ack("recover", n, pd);
      req = 4'b0000;
      check("recover_latency", 32'(n), 5);
      check("recover_err", 32'(res_err), 0);
      check("recover_even", 32'(res_even), 0);
      check("recover_odd", 32'(res_odd), 1);
      @(negedge clk);

      // Asynchronous reset mid-RUN
      eng_len = 8;
      req_data = 32'h3C00_0000;
      req = 4'b1000;
      repeat (5) @(negedge clk);
      check("midrun_active", 32'(active), 1);
      check("midrun_busy", 32'(par_busy), 1);
      #1 reset = 1'b1;
      #1;
      check("arst_ack", 32'(ack), 0);
      check("arst_res", 32'({res_even, res_odd, res_err}), 0);
      check("arst_grant", 32'(grant_id), 0);
      check("arst_active", 32'(active), 0);
      check("arst_start", 32'(par_start), 0);
      check("arst_pdata", 32'(par_data), 0);
      @(negedge clk);
      reset = 1'b0;
      req = 4'b0000;
      base = starts;
      repeat (20) @(negedge clk);
      check("idle_no_start", 32'(starts - base), 0);
      check("idle_active", 32'(active), 0);

      // Round robin with all four held high: pointer restarts at 0 after reset
      eng_len = 2;
      req_data = 32'h4433_2211;
      req = 4'b1111;
      for (int t = 0; t < 5; t++) begin
         wait_ack($sformatf("rr%0d", t), n, pd);
         check($sformatf("rr%0d_grant", t), 32'(grant_id), 32'(order[t]));
         check($sformatf("rr%0d_ack", t), 32'(ack), 32'(1) << order[t]);
      end
      req = 4'b0000;
      check("rr_last_pdata", 32'(par_data), 32'h11);
      @(negedge clk);

      // Mid-transaction arrival: 3 is granted (pointer at 1), 1 arrives while 3 runs
      eng_len = 4;
      req_data = 32'hF000_8100;
      req = 4'b1000;
      repeat (3) @(negedge clk);
      req = 4'b1010;
      wait_ack("mid3", n, pd);
      check("mid3_grant", 32'(grant_id), 3);
      check("mid3_ack", 32'(ack), 32'h8);
      check("mid3_latency", 32'(n + 3), 7);
      req = 4'b0010;
      wait_ack("mid1", n, pd);
      req = 4'b0000;
      check("mid1_grant", 32'(grant_id), 1);
      check("mid1_ack", 32'(ack), 32'h2);
      check("mid1_gap", 32'(n), 8);
      check("mid1_pdata", 32'(par_data), 32'h81);
      check("mid1_even", 32'(res_even), 0);
      check("mid1_odd", 32'(res_odd), 1);
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout observed=running expected=finished");
      $fatal(1, "bench time limit reached");
   end

endmodule
